// File: rtl/bcd_down_timer.sv
// Two-digit BCD down timer (99..00) with prescaled TICK input.
// Optional: define BCD_DOWN_TIMER_AUTO_RELOAD_EN to reload the preset on expiry.
module bcd_down_timer #(
    parameter int PRESCALE = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TICK,
    input  logic       LOAD,
    input  logic [3:0] LOAD_TENS,
    input  logic [3:0] LOAD_ONES,
    input  logic       START,
    input  logic       PAUSE,
    output logic [3:0] D_TENS,
    output logic [3:0] D_ONES,
    output logic       BUSY,
    output logic       DONE
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        EXPIRED
    } state_t;

    localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

    state_t     state, state_n;
    logic [3:0] tens_n, ones_n;
    logic [3:0] rtens, rones, rtens_n, rones_n;
    logic [7:0] pre, pre_n;
    logic       done_n;
    logic [3:0] dec_tens, dec_ones;
    logic       is_zero, is_one;

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    assign is_zero  = (D_TENS == 4'd0) && (D_ONES == 4'd0);
    assign is_one   = (D_TENS == 4'd0) && (D_ONES == 4'd1);
    assign dec_ones = (D_ONES == 4'd0) ? 4'd9 : D_ONES - 4'd1;
    assign dec_tens = (D_ONES == 4'd0) ? D_TENS - 4'd1 : D_TENS;
    assign BUSY     = (state == RUN) || (state == PAUSED);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            D_TENS <= 4'd0;
            D_ONES <= 4'd0;
            rtens  <= 4'd0;
            rones  <= 4'd0;
            pre    <= 8'd0;
            DONE   <= 1'b0;
        end else begin
            state  <= state_n;
            D_TENS <= tens_n;
            D_ONES <= ones_n;
            rtens  <= rtens_n;
            rones  <= rones_n;
            pre    <= pre_n;
            DONE   <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        tens_n  = D_TENS;
        ones_n  = D_ONES;
        rtens_n = rtens;
        rones_n = rones;
        pre_n   = pre;
        done_n  = 1'b0;
        if (LOAD) begin
            tens_n  = clamp9(LOAD_TENS);
            ones_n  = clamp9(LOAD_ONES);
            rtens_n = clamp9(LOAD_TENS);
            rones_n = clamp9(LOAD_ONES);
            pre_n   = 8'd0;
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (START && !is_zero)
                        state_n = RUN;
                end
                RUN: begin
                    // PAUSE also swallows a coincident TICK
                    if (PAUSE) begin
                        state_n = PAUSED;
                    end else if (TICK) begin
                        if (pre == PRE_LAST) begin
                            pre_n = 8'd0;
                            if (is_one) begin
                                done_n = 1'b1;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
                                tens_n = rtens;
                                ones_n = rones;
`else
                                tens_n  = 4'd0;
                                ones_n  = 4'd0;
                                state_n = EXPIRED;
`endif
                            end else begin
                                tens_n = dec_tens;
                                ones_n = dec_ones;
                            end
                        end else begin
                            pre_n = pre + 8'd1;
                        end
                    end
                end
                PAUSED: begin
                    if (START && !PAUSE)
                        state_n = RUN;
                end
                EXPIRED: begin
                    state_n = EXPIRED;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/bcd_down_timer.md
BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

Interface
REQ-001 SHALL have parameter: PRESCALE, default 1, number of accepted TICK strobes per decrement (legal range 1..255).
REQ-002 SHALL have port: CLK  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port: RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: TICK  input  1  count strobe, sampled each CLK edge.
REQ-005 SHALL have port: LOAD  input  1  load preset from LOAD_TENS/LOAD_ONES.
REQ-006 SHALL have port: LOAD_TENS  input  4  preset tens digit, BCD.
REQ-007 SHALL have port: LOAD_ONES  input  4  preset ones digit, BCD.
REQ-008 SHALL have port: START  input  1  start or resume counting.
REQ-009 SHALL have port: PAUSE  input  1  suspend counting.
REQ-010 SHALL have port: D_TENS  output  4  current tens digit, registered.
REQ-011 SHALL have port: D_ONES  output  4  current ones digit, registered.
REQ-012 SHALL have port: BUSY  output  1  high in RUN or PAUSED.
REQ-013 SHALL have port: DONE  output  1  one-cycle expiry pulse, registered.

Function
REQ-014 SHALL implement a two-digit BCD down counter, range 99..00, with states IDLE, RUN, PAUSED, EXPIRED.
REQ-015 SHALL give LOAD top priority in every state: digits <= preset, reload register <= preset, prescaler <= 0, state <= IDLE, DONE <= 0.
REQ-016 SHALL clamp any preset digit above 9 to 9 on load, so 4'hC loads as 9.
REQ-017 SHALL, in IDLE with START and digits != 00, enter RUN on the next edge; SHALL ignore START when digits == 00.
REQ-018 SHALL, in RUN, increment the prescaler on each edge with TICK=1, and SHALL decrement the digits on the edge where TICK=1 and the prescaler equals PRESCALE-1; the prescaler SHALL then return to 0.
REQ-019 SHALL borrow on decrement: when the ones digit is 0 it becomes 9 and the tens digit decrements; digits SHALL never hold a value above 9.
REQ-020 SHALL, on the decrement from 01, assert DONE for exactly one cycle, registered on the same edge as the new digit value.
REQ-021 SHALL, in RUN with PAUSE=1, enter PAUSED and discard a coincident TICK; PAUSE SHALL win over START in the same cycle.
REQ-022 SHALL, in PAUSED, hold digits and prescaler and return to RUN on START with PAUSE=0.
REQ-023 SHALL, in EXPIRED, hold 00, ignore START, PAUSE and TICK, and leave only via LOAD or RST.
REQ-024 SHALL drive BUSY combinationally from state (RUN or PAUSED) and SHALL drive DONE low in every cycle not covered by REQ-020.

Reset
REQ-025 SHALL, on RST=1 at a CLK edge, set state IDLE, D_TENS=0, D_ONES=0, reload register 00, prescaler 0, DONE=0, BUSY=0.
REQ-026 SHALL give RST priority over LOAD and all other inputs, including mid-RUN; no DONE pulse SHALL follow reset.

Configuration
REQ-027 SHALL support the macro BCD_DOWN_TIMER_AUTO_RELOAD_EN.
REQ-028 SHALL, with BCD_DOWN_TIMER_AUTO_RELOAD_EN defined, on the decrement from 01 load the digits from the reload register (not 00), pulse DONE and remain in RUN; EXPIRED SHALL be unreachable.
REQ-029 SHALL, without the macro, behave per REQ-020/REQ-023, with the counter going to 00 and then EXPIRED.

Verification
REQ-030 SHALL cover: PRESCALE=1, LOAD 12, START, TICK every cycle -> digits 11,10,09,...,01,00; DONE high for one cycle with 00; BUSY low afterwards.
REQ-031 SHALL cover: PRESCALE=3, LOAD 05, START, continuous TICK -> a decrement on every 3rd tick edge; 00 and DONE reached 15 TICK edges after START.
REQ-032 SHALL cover: RUN at 07 with PAUSE and TICK asserted in the same cycle -> hold at 07 and BUSY=1; START then gives 06 on the next TICK.
REQ-033 SHALL cover: LOAD_TENS=4'hF, LOAD_ONES=4'hA -> 99; START at 00 ignored with BUSY=0; RST asserted mid-RUN at 42 -> 00 and IDLE with no DONE.
REQ-034 SHALL cover: with BCD_DOWN_TIMER_AUTO_RELOAD_EN, LOAD 03, START, TICK every cycle -> 02,01,03,02,... with a DONE pulse each time 03 reloads and BUSY staying high.
